// File: rtl/quire_to_posit.sv
// quire_to_posit: rounds a 16N-bit two's-complement quire to posit<N,2> (RNE, saturating), iterative 16-bit leading-one scan.
// Optional flags port {nar, saturated, inexact} enabled by defining QUIRE2POSIT_FLAGS_EN.
module quire_to_posit #(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [16*N-1:0] quire_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_posit
`ifdef QUIRE2POSIT_FLAGS_EN
  ,
  output logic [2:0]      out_flags
`endif
);
  localparam int QW = 16 * N;
  localparam int SW = $clog2(QW) + 2;
  localparam int JW = $clog2(N);
  localparam int W = QW + 3 + N;
  localparam logic signed [SW-1:0] SMAX = SW'(4 * N - 8);
  typedef enum logic [2:0] {IDLE, CHECK, SCAN, NORM, ENC, DONE} state_t;
  state_t state_q;
  logic [QW-1:0] work_q;
  logic sign_q, spec_q, sat_q, in_ready_q, out_valid_q;
  logic [JW-1:0] j_q;
  logic signed [SW-1:0] s_q;
  logic [N-1:0] posit_q;
  logic [3:0] lz;
  logic signed [SW-1:0] s_raw, s_d, k;
  logic sat_d;
  logic [SW-1:0] a;
  logic [W-1:0] str;
  logic [N-2:0] top;
  logic guard, sticky, rnd;
  logic [N-1:0] mag, mag_c, posit_d;
`ifdef QUIRE2POSIT_FLAGS_EN
  logic [2:0] flags_q;
  logic inexact_d;
  assign inexact_d = guard | sticky;
  assign out_flags = flags_q;
`endif
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_posit = posit_q;
  always_comb begin
    lz = 4'd0;
    for (int i = 0; i < 16; i++) if (work_q[QW-16+i]) lz = 4'(15 - i);
    s_raw = SW'(8 * N + 15) - SW'({j_q, 4'b0}) - SW'(lz);
    sat_d = s_raw > SMAX || s_raw < -SMAX;
    s_d = s_raw > SMAX ? SMAX : s_raw < -SMAX ? -SMAX : s_raw;
  end
  // Regime is built by a fill-shift of a 2-bit seed: "10" filled with ones for k>=0, "01" filled with zeros for k<0.
  always_comb begin
    k = s_q >>> 2;
    a = k[SW-1] ? ~k : k;
    str = ({~k[SW-1], k[SW-1], s_q[1:0], work_q[QW-2:0], N'(0)} >> a) | ({W{~k[SW-1]}} & ~({W{1'b1}} >> a));
    top = str[W-1 -: N-1];
    guard = str[W-N];
    sticky = (|str[W-N-1:0]) | sat_q;
    rnd = guard & (top[0] | sticky);
    mag = {1'b0, top} + N'(rnd);
    mag_c = mag == '0 ? N'(1) : mag[N-1] ? {1'b0, {(N-1){1'b1}}} : mag;
    posit_d = sign_q ? -mag_c : mag_c;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      posit_q <= '0;
      work_q <= '0;
      sign_q <= 1'b0;
      spec_q <= 1'b0;
      sat_q <= 1'b0;
      j_q <= '0;
      s_q <= '0;
`ifdef QUIRE2POSIT_FLAGS_EN
      flags_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          work_q <= quire_in;
          in_ready_q <= 1'b0;
          state_q <= CHECK;
        end
        // Zero and NaR share all-zero low bits; both take the ENC slot so their latency is two cycles.
        CHECK: begin
          spec_q <= work_q[QW-2:0] == '0;
          sign_q <= work_q[QW-1];
          work_q <= work_q[QW-1] ? -work_q : work_q;
          j_q <= '0;
          posit_q <= {work_q[QW-1], {(N-1){1'b0}}};
`ifdef QUIRE2POSIT_FLAGS_EN
          flags_q <= {work_q[QW-1], 2'b00};
`endif
          state_q <= work_q[QW-2:0] == '0 ? ENC : SCAN;
        end
        SCAN: if (|work_q[QW-1 -: 16]) state_q <= NORM;
        else begin
          work_q <= work_q << 16;
          j_q <= j_q + 1'b1;
        end
        NORM: begin
          work_q <= work_q << lz;
          s_q <= s_d;
          sat_q <= sat_d;
          state_q <= ENC;
        end
        ENC: begin
          if (!spec_q) begin
            posit_q <= posit_d;
`ifdef QUIRE2POSIT_FLAGS_EN
            flags_q <= {1'b0, sat_q, inexact_d};
`endif
          end
          out_valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_quire_to_posit.sv
// tb_quire_to_posit: directed vectors checked against a value-enumeration model of posit<8,2> rounding.
module tb_quire_to_posit;
  localparam logic [127:0] ONE = 128'd1;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [127:0] quire_in = '0;
  logic in_ready, out_valid;
  logic [7:0] out_posit;
`ifdef QUIRE2POSIT_FLAGS_EN
  logic [2:0] out_flags;
`endif
  int tests = 0;
  int fails = 0;
  typedef struct packed {
    logic [7:0] p;
    logic [2:0] fl;
    logic [7:0] lat;
  } exp_t;
  exp_t expq[$];

  quire_to_posit #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .quire_in(quire_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_posit(out_posit)
`ifdef QUIRE2POSIT_FLAGS_EN
    , .out_flags(out_flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Value of a positive posit<n,2> pattern, scaled by 2^48 (quire units).
  function automatic logic [127:0] pval(input logic [8:0] b, input int n);
    int i, run, k, e, fb;
    logic first;
    logic [127:0] f;
    i = n - 2;
    first = b[i];
    run = 0;
    while (i >= 0 && b[i] == first) begin
      run++;
      i--;
    end
    if (i >= 0) i--;
    k = first ? run - 1 : -run;
    e = 0;
    for (int t = 0; t < 2; t++) begin
      e = e * 2 + ((i >= 0 && b[i]) ? 1 : 0);
      if (i >= 0) i--;
    end
    fb = i + 1;
    f = 128'(b) & ((ONE << fb) - ONE);
    return ((ONE << fb) + f) << (4 * k + e + 48 - fb);
  endfunction

  function automatic exp_t model(input logic [127:0] q);
    exp_t r;
    logic neg, sat, exact;
    logic [127:0] a, m;
    int msb, best, res;
    if (q == (ONE << 127)) return '{p: 8'h80, fl: 3'b100, lat: 8'd2};
    if (q == '0) return '{p: 8'h00, fl: 3'b000, lat: 8'd2};
    neg = q[127];
    a = neg ? -q : q;
    msb = 0;
    for (int i = 0; i < 128; i++) if (a[i]) msb = i;
    best = 0;
    exact = 1'b0;
    for (int p = 1; p < 128; p++) begin
      if (pval(9'(p), 8) <= a) best = p;
      if (pval(9'(p), 8) == a) exact = 1'b1;
    end
    sat = (a >> 73) != '0 || a < (ONE << 24);
    if (best == 0) res = 1;
    else if (best == 127) res = 127;
    else begin
      m = pval({8'(best), 1'b1}, 9);
      res = a > m ? best + 1 : a < m ? best : best + (best % 2);
    end
    r.p = neg ? 8'(-res) : 8'(res);
    r.fl = {1'b0, sat, ~exact};
    r.lat = 8'((127 - msb) / 16 + 4);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expq.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'd0);
      else begin
        check("out_posit", 32'(out_posit), 32'(expq[0].p));
`ifdef QUIRE2POSIT_FLAGS_EN
        check("out_flags", 32'(out_flags), 32'(expq[0].fl));
`endif
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic run(input logic [127:0] q, input int exp_p, input int exp_fl, input int exp_lat, input int hold);
    exp_t e;
    int cnt;
    e = model(q);
    if (exp_p >= 0) check("model_posit", 32'(e.p), 32'(exp_p));
    if (exp_fl >= 0) check("model_flags", 32'(e.fl), 32'(exp_fl));
    if (exp_lat >= 0) check("model_latency", 32'(e.lat), 32'(exp_lat));
    expq.push_back(e);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    quire_in = q;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      check("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 cnt++;
    end
    check("latency", 32'(cnt), 32'(e.lat));
    repeat (hold) begin
      in_valid = 1'b1;
      quire_in = ONE << 48;
      check("in_ready_hold", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_posit", 32'(out_posit), 32'd0);
`ifdef QUIRE2POSIT_FLAGS_EN
    check("reset_out_flags", 32'(out_flags), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(ONE << 48, 'h40, 3'b000, 8, 0);
    run(-(128'd3 << 47), 'hBC, 3'b000, 8, 0);
    run(ONE << 78, 'h7F, 3'b011, 7, 0);
    run(ONE << 8, 'h01, 3'b011, 11, 0);
    run('0, 'h00, 3'b000, 2, 0);
    run(ONE << 127, 'h80, 3'b100, 2, 0);
    run((ONE << 48) | (ONE << 44) | ONE, 'h41, 3'b001, 8, 0);
    run((ONE << 48) | (ONE << 44), 'h40, 3'b001, 8, 0);
    run(ONE << 49, 'h48, 3'b000, 8, 0);
    run(ONE << 47, 'h38, 3'b000, 9, 0);
    run(ONE << 72, 'h7F, 3'b000, 7, 0);
    run(ONE << 24, 'h01, 3'b000, 10, 0);
    run('1, 'hFF, 3'b011, 11, 0);
    run(128'd3 << 47, 'h44, 3'b000, 8, 10);
    for (int b = 0; b < 127; b += 7) begin
      run(ONE << b, -1, -1, -1, 0);
      run(-(ONE << b) - 128'd5, -1, -1, -1, 0);
      run((128'hB7 << b) | 128'h3, -1, -1, -1, 0);
    end
    in_valid = 1'b1;
    quire_in = ONE << 8;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("busy_before_reset", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_out_posit", 32'(out_posit), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(ONE << 49, 'h48, 3'b000, 8, 2);
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
